pcpi_fpdiv_issuer: RTL and testbench
====================================

# pcpi_fpdiv_issuer

Initiator side of the FP32 divider's STB/BUSY handshake. Decodes the custom FDIV.S instruction presented on the PicoRV32 PCPI port, launches the operands into the divider core, and collects the quotient with the output-side handshake. It returns the quotient to the CPU as an rd write, and sits between the CPU PCPI bus and the divider in the co-processor.

## Interface
- OPCODE, 7'b0001011: custom-0 major opcode matched on pcpi_insn[6:0].
- FUNCT3, 3'b000: matched on pcpi_insn[14:12].
- FUNCT7, 7'b0000100: matched on pcpi_insn[31:25].
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcpi_valid  in  1  CPU presents an instruction.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1, pcpi_rs2  in  32  dividend / divisor (FP32 bit patterns).
- pcpi_wr  out  1  rd write enable, valid with pcpi_ready.
- pcpi_rd  out  32  quotient.
- pcpi_wait  out  1  instruction claimed, result pending.
- pcpi_ready  out  1  one-cycle completion pulse.
- div_a, div_b  out  32  operands to divider.
- div_stb  out  1  operands valid.
- div_busy  in  1  divider not accepting operands.
- div_res  in  32  divider quotient.
- div_res_stb  in  1  quotient valid.
- div_res_busy  out  1  this block not accepting a quotient (low = accept).

## Operation
- match = pcpi_valid & opcode/funct3/funct7 equal to the parameters. The rs fields and rd field are ignored. The CPU does the register access.
- States: IDLE, ISSUE, WAIT_RES, RESP, DRAIN, COOL.
- IDLE: div_res_busy=1.
  - On match, latch rs1→div_a and rs2→div_b, set div_stb=1 and pcpi_wait=1, then go to ISSUE.
  - On non-match, stay in IDLE with no outputs changed.
- ISSUE: transfer occurs at the edge where div_stb=1 & div_busy=0.
  - At that edge, div_stb←0, div_res_busy←0, and go to WAIT_RES.
  - div_a/div_b/div_stb are held stable while div_busy=1, for an unbounded time.
- WAIT_RES: quotient transfer occurs at the edge where div_res_stb=1 & div_res_busy=0.
  - At that edge, capture div_res into pcpi_rd and set div_res_busy←1.
  - If pcpi_valid is still 1, go to RESP; otherwise go to COOL (result discarded).
- RESP: pcpi_ready=1, pcpi_wr=1 and pcpi_wait←0 for exactly this cycle, then go to COOL.
- COOL: one idle cycle that guarantees the same instruction is never re-decoded. Go to IDLE.
- Abort: if pcpi_valid falls in ISSUE or WAIT_RES:
  - pcpi_wait←0 immediately, the FSM goes to DRAIN (the abort marker), and no pcpi_ready is issued.
  - An in-flight issue is still completed: div_stb is held until accepted.
  - The quotient is still consumed, so the divider is never left stranded. Then go to COOL.
- pcpi_rd holds its last captured value outside RESP; the CPU ignores it unless pcpi_ready=1.
- Data is passed through bit-exact; no FP interpretation here. NaN/Inf/zero handling belongs to the divider.

## Timing
- Reset values: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, div_a=0, div_b=0, div_stb=0, div_res_busy=1, state=IDLE.
- Reset mid-operation forces these values asynchronously. A divider holding a quotient keeps div_res_stb high; after reset this block ignores it (div_res_busy=1) until the next issue. The divider is reset on the same net.
- pcpi_wait is registered and rises 1 cycle after the first match cycle. This is well inside the CPU's 16-cycle PCPI timeout.
- Latency from match to pcpi_ready = 1 (latch) + issue stall + divider latency + 1 (capture) + 1 (RESP), with a minimum overhead of 3 cycles plus the divider latency.
- Simultaneous div_res_stb and pcpi_valid fall in the same cycle: the capture happens and the FSM goes to COOL with no pcpi_ready.
- Back-to-back instructions: the next match is honoured no earlier than 2 cycles after pcpi_ready.

## Structure
- The shared package fpu_copro_pkg holds:
  - the OPCODE_CUSTOM0, FDIV_FUNCT3 and FDIV_FUNCT7 constants;
  - the state enum;
  - a pcpi_match() function, reused by the future multiplier/adder issuers.
- Sub-module pcpi_insn_decode: combinational match from pcpi_insn, parameterised by OPCODE/FUNCT3/FUNCT7. Everything else lives in the single FSM.

## Test plan
- 6.0/2.0: rs1=0x40C00000, rs2=0x40000000 with a divider model -> div_a/div_b latched, one accepted div_stb, pcpi_ready pulse with pcpi_wr=1 and pcpi_rd=0x40400000.
- Special value passthrough: rs1=0x3F800000, rs2=0x00000000 -> pcpi_rd=0x7F800000 unchanged.
- Issue backpressure: div_busy held 1 for 5 cycles -> div_stb and operands stable for all 5 cycles, single transfer, pcpi_wait high throughout.
- Non-matching insn (funct7=0000001) -> pcpi_wait, pcpi_ready and div_stb all stay 0 for 20 cycles.
- Abort: drop pcpi_valid in WAIT_RES -> quotient still consumed (div_res_busy low until transfer), no pcpi_ready. A following 9.0/3.0 (0x41100000/0x40400000) returns 0x40400000.
- resetn low for 1 cycle during ISSUE -> all outputs at reset values immediately. The next instruction completes normally.

Source files
------------

// File: rtl/fpu_copro_pkg.sv
// Shared definitions for the FP co-processor PCPI issuers: instruction encodings,
// issuer FSM states and the instruction match helper.
package fpu_copro_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] FDIV_FUNCT3    = 3'b000;
  localparam logic [6:0] FDIV_FUNCT7    = 7'b0000100;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    RESP,
    DRAIN,
    COOL
  } issuer_state_t;

  // Register fields are deliberately ignored; the CPU performs register access.
  function automatic logic pcpi_match(input logic [31:0] insn,
                                      input logic [6:0]  opcode,
                                      input logic [2:0]  funct3,
                                      input logic [6:0]  funct7);
    return (insn[6:0] == opcode) && (insn[14:12] == funct3) && (insn[31:25] == funct7);
  endfunction

endpackage

// File: rtl/pcpi_insn_decode.sv
// Combinational R-type instruction matcher, parameterised by opcode/funct3/funct7.
module pcpi_insn_decode
  import fpu_copro_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter logic [2:0] FUNCT3 = FDIV_FUNCT3,
  parameter logic [6:0] FUNCT7 = FDIV_FUNCT7
) (
  input  logic [31:0] insn,
  output logic        match
);

  assign match = pcpi_match(insn, OPCODE, FUNCT3, FUNCT7);

endmodule

// File: rtl/pcpi_fpdiv_issuer.sv
// PCPI front end for the FP32 divider: decodes FDIV.S, issues operands over the
// STB/BUSY handshake, collects the quotient and returns it as an rd write.
module pcpi_fpdiv_issuer
  import fpu_copro_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_stb,
  input  logic        div_busy,
  input  logic [31:0] div_res,
  input  logic        div_res_stb,
  output logic        div_res_busy
);

  issuer_state_t state_reg, state_next;
  logic [31:0]   div_a_reg, div_a_next;
  logic [31:0]   div_b_reg, div_b_next;
  logic [31:0]   rd_reg, rd_next;
  logic          stb_reg, stb_next;
  logic          res_busy_reg, res_busy_next;
  logic          wait_reg, wait_next;
  logic          insn_match;
  logic          issue_xfer;
  logic          res_xfer;

  pcpi_insn_decode #(
    .OPCODE (OPCODE_CUSTOM0),
    .FUNCT3 (FDIV_FUNCT3),
    .FUNCT7 (FDIV_FUNCT7)
  ) u_decode (
    .insn  (pcpi_insn),
    .match (insn_match)
  );

  assign issue_xfer = stb_reg & ~div_busy;
  assign res_xfer   = div_res_stb & ~res_busy_reg;

  always_comb begin
    state_next    = state_reg;
    div_a_next    = div_a_reg;
    div_b_next    = div_b_reg;
    rd_next       = rd_reg;
    stb_next      = stb_reg;
    res_busy_next = res_busy_reg;
    wait_next     = wait_reg;
    case (state_reg)
      IDLE: begin
        if (pcpi_valid && insn_match) begin
          div_a_next = pcpi_rs1;
          div_b_next = pcpi_rs2;
          stb_next   = 1'b1;
          wait_next  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_xfer) begin
          stb_next      = 1'b0;
          res_busy_next = 1'b0;
        end
        // An abort still lets DRAIN finish the operand transfer and eat the quotient.
        if (!pcpi_valid) begin
          wait_next  = 1'b0;
          state_next = DRAIN;
        end else if (issue_xfer) begin
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (res_xfer) begin
          rd_next       = div_res;
          res_busy_next = 1'b1;
          wait_next     = 1'b0;
          state_next    = pcpi_valid ? RESP : COOL;
        end else if (!pcpi_valid) begin
          wait_next  = 1'b0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (issue_xfer) begin
          stb_next      = 1'b0;
          res_busy_next = 1'b0;
        end else if (res_xfer) begin
          res_busy_next = 1'b1;
          state_next    = COOL;
        end
      end
      RESP:    state_next = COOL;
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      div_a_reg    <= '0;
      div_b_reg    <= '0;
      rd_reg       <= '0;
      stb_reg      <= 1'b0;
      res_busy_reg <= 1'b1;
      wait_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_a_reg    <= div_a_next;
      div_b_reg    <= div_b_next;
      rd_reg       <= rd_next;
      stb_reg      <= stb_next;
      res_busy_reg <= res_busy_next;
      wait_reg     <= wait_next;
    end
  end

  assign pcpi_ready   = (state_reg == RESP);
  assign pcpi_wr      = (state_reg == RESP);
  assign pcpi_rd      = rd_reg;
  assign pcpi_wait    = wait_reg;
  assign div_a        = div_a_reg;
  assign div_b        = div_b_reg;
  assign div_stb      = stb_reg;
  assign div_res_busy = res_busy_reg;

endmodule

// File: tb/tb_pcpi_fpdiv_issuer.sv
// Directed bench for pcpi_fpdiv_issuer with a behavioural divider on the far side.
module tb_pcpi_fpdiv_issuer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd, div_a, div_b;
  logic        div_stb, div_busy, div_res_busy;
  logic [31:0] div_res;
  logic        div_res_stb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcpi_fpdiv_issuer dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_stb      (div_stb),
    .div_busy     (div_busy),
    .div_res      (div_res),
    .div_res_stb  (div_res_stb),
    .div_res_busy (div_res_busy)
  );

  // Behavioural divider: hand-computed quotient table, programmable latency.
  logic        busy_force = 1'b0;
  int          m_lat = 3;
  int          m_cnt;
  logic        m_active;
  logic [31:0] m_q;
  logic        m_stb;
  int          accept_cnt = 0;
  int          consume_cnt = 0;

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
    if (a == 32'h41100000 && b == 32'h40400000) return 32'h40400000;
    if (a == 32'hC0800000 && b == 32'h40000000) return 32'hC0000000;
    return 32'h7FC00000;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_stb    <= 1'b0;
      m_cnt    <= 0;
      m_q      <= '0;
    end else if (div_stb && !div_busy) begin
      m_active   <= 1'b1;
      m_cnt      <= m_lat;
      m_q        <= quot(div_a, div_b);
      accept_cnt <= accept_cnt + 1;
    end else if (m_active && !m_stb) begin
      if (m_cnt == 0) m_stb <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end else if (m_stb && !div_res_busy) begin
      m_stb       <= 1'b0;
      m_active    <= 1'b0;
      consume_cnt <= consume_cnt + 1;
    end
  end

  assign div_busy    = m_active | busy_force;
  assign div_res     = m_q;
  assign div_res_stb = m_stb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] insn;
    int          busy;
    logic        exp_ready;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int acc0;
    int n;
    @(negedge clk);
    busy_force = (v.busy > 0);
    pcpi_valid = 1'b1;
    pcpi_insn  = v.insn;
    pcpi_rs1   = v.rs1;
    pcpi_rs2   = v.rs2;
    acc0       = accept_cnt;
    @(negedge clk);
    if (v.exp_ready) begin
      check({v.name, " wait_rise"}, {31'd0, pcpi_wait}, 32'd1);
      check({v.name, " stb"}, {31'd0, div_stb}, 32'd1);
      check({v.name, " div_a"}, div_a, v.rs1);
      check({v.name, " div_b"}, div_b, v.rs2);
      for (int i = 1; i < v.busy; i++) begin
        @(negedge clk);
        check({v.name, " hold_stb"}, {31'd0, div_stb}, 32'd1);
        check({v.name, " hold_ops"}, div_a ^ div_b, v.rs1 ^ v.rs2);
        check({v.name, " hold_wait"}, {31'd0, pcpi_wait}, 32'd1);
      end
      busy_force = 1'b0;
      n = 0;
      while (!pcpi_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check({v.name, " ready_seen"}, {31'd0, pcpi_ready}, 32'd1);
      check({v.name, " wr"}, {31'd0, pcpi_wr}, 32'd1);
      check({v.name, " rd"}, pcpi_rd, v.exp_rd);
      check({v.name, " accepts"}, accept_cnt - acc0, 32'd1);
      pcpi_valid = 1'b0;
      @(negedge clk);
      check({v.name, " ready_pulse"}, {30'd0, pcpi_ready, pcpi_wait}, 32'd0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        check({v.name, " idle_outs"}, {29'd0, pcpi_wait, pcpi_ready, div_stb}, 32'd0);
        @(negedge clk);
      end
      check({v.name, " no_accept"}, accept_cnt - acc0, 32'd0);
      pcpi_valid = 1'b0;
      busy_force = 1'b0;
    end
    $display("vector %s rs1=%h rs2=%h rd=%h", v.name, v.rs1, v.rs2, pcpi_rd);
  endtask

  vec_t        vecs[6];
  vec_t        v93;
  logic [31:0] insn_fdiv;
  logic [31:0] insn_f7;
  logic [31:0] insn_f3;

  initial begin
    int   cons0;
    int   n;
    logic saw_ready;

    insn_fdiv = {7'b0000100, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
    insn_f7   = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
    insn_f3   = {7'b0000100, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0001011};
    vecs[0] = '{"div6_2",     32'h40C00000, 32'h40000000, insn_fdiv, 0, 1'b1, 32'h40400000};
    vecs[1] = '{"div1_0",     32'h3F800000, 32'h00000000, insn_fdiv, 0, 1'b1, 32'h7F800000};
    vecs[2] = '{"backpress",  32'h40C00000, 32'h40000000, insn_fdiv, 5, 1'b1, 32'h40400000};
    vecs[3] = '{"bad_funct7", 32'h40C00000, 32'h40000000, insn_f7,   0, 1'b0, 32'h0};
    vecs[4] = '{"bad_funct3", 32'h40C00000, 32'h40000000, insn_f3,   0, 1'b0, 32'h0};
    vecs[5] = '{"divm4_2",    32'hC0800000, 32'h40000000, insn_fdiv, 1, 1'b1, 32'hC0000000};
    v93     = '{"div9_3",     32'h41100000, 32'h40400000, insn_fdiv, 0, 1'b1, 32'h40400000};

    #23;
    check("rst_ctrl", {27'd0, pcpi_wr, pcpi_ready, pcpi_wait, div_stb, div_res_busy}, 32'd1);
    check("rst_rd", pcpi_rd, 32'd0);
    check("rst_ops", div_a | div_b, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort while waiting for the quotient: it must still be consumed, with no ready.
    m_lat = 6;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn_fdiv;
    pcpi_rs1   = 32'h40C00000;
    pcpi_rs2   = 32'h40000000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_res_busy && n < 50);
    check("abort reach_wait", {31'd0, div_res_busy}, 32'd0);
    pcpi_valid = 1'b0;
    cons0 = consume_cnt;
    saw_ready = 1'b0;
    @(negedge clk);
    check("abort wait_drop", {31'd0, pcpi_wait}, 32'd0);
    check("abort still_accepting", {31'd0, div_res_busy}, 32'd0);
    n = 0;
    while (consume_cnt == cons0 && n < 50) begin
      saw_ready |= pcpi_ready;
      @(negedge clk);
      n++;
    end
    saw_ready |= pcpi_ready;
    check("abort consumed", consume_cnt - cons0, 32'd1);
    check("abort no_ready", {31'd0, saw_ready}, 32'd0);
    check("abort res_busy_back", {31'd0, div_res_busy}, 32'd1);
    $display("abort sequence consumed=%0d", consume_cnt - cons0);
    m_lat = 3;
    run_vec(v93);

    // Reset pulse while the issue is stalled.
    @(negedge clk);
    busy_force = 1'b1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn_fdiv;
    pcpi_rs1   = 32'h41100000;
    pcpi_rs2   = 32'h40400000;
    @(negedge clk);
    check("rst_mid in_issue", {31'd0, div_stb}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid ctrl", {27'd0, pcpi_wr, pcpi_ready, pcpi_wait, div_stb, div_res_busy}, 32'd1);
    check("rst_mid rd", pcpi_rd, 32'd0);
    check("rst_mid ops", div_a | div_b, 32'd0);
    @(negedge clk);
    resetn     = 1'b1;
    pcpi_valid = 1'b0;
    busy_force = 1'b0;
    $display("reset during issue applied");
    run_vec(v93);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
